// File: rtl/alu_issue_wb_if.sv
// Instruction-in and writeback-out bundle for the ALU issue/writeback stage.
// Latency: none; this is wiring only.
// Backpressure: in_ready from the stage gates in_valid; writeback has no backpressure.
interface alu_issue_wb_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [2:0]       in_rd;
    logic [2:0]       in_rs1;
    logic [2:0]       in_rs2;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_imm;
    logic [4:0]       in_shamt;
    logic             wb_valid;
    logic [2:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       flags;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_shamt,
        input  in_ready, wb_valid, wb_rd, wb_data, flags
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_use_imm, in_imm, in_shamt,
        output in_ready, wb_valid, wb_rd, wb_data, flags
    );
endinterface

// File: rtl/alu_issue_wb.sv
// Operand issue + writeback around an external combinational ALU, with an instruction FIFO and register file.
// Latency: accepted at edge k -> issued at k+1 -> written back at k+2; one op per cycle.
// Backpressure: in_ready = FIFO not full (registered count only); hold stalls issue, FIFO keeps filling.
module alu_issue_wb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_wb_if.slave    bus,
    input  logic             hold,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_sign,
    input  logic [2:0]       rf_rd_addr,
    output logic [WIDTH-1:0] rf_rd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [3:0]       opcode;
        logic [2:0]       rd;
        logic [2:0]       rs1;
        logic [2:0]       rs2;
        logic             use_imm;
        logic [WIDTH-1:0] imm;
        logic [4:0]       shamt;
    } instr_t;

    instr_t           mem [DEPTH];
    instr_t           in_entry;
    instr_t           head;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             issue_valid;
    logic [2:0]       issue_rd;
    logic             retire;
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;

    assign in_entry     = {bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                           bus.in_use_imm, bus.in_imm, bus.in_shamt};
    assign head         = mem[rd_ptr];
    assign bus.in_ready = (count != FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    // Pop looks only at the registered count, so a same-cycle push into an empty FIFO waits a cycle.
    assign pop          = (count != '0) && !hold;
    // Opcodes 9..15 are NOPs: they occupy the issue slot but never retire or forward.
    assign retire       = issue_valid && (alu_opcode <= 4'd8);
    assign rf_rd_data   = (rf_rd_addr == 3'd0) ? '0 : rf[rf_rd_addr];

    // FIFO payload storage; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Operand select: the RF write for the op in the ALU lands on the same edge this op issues,
    // so that op's result must be forwarded directly from the ALU output.
    always_comb begin
        op1 = rf[head.rs1];
        if (head.rs1 == 3'd0) begin
            op1 = '0;
        end else if (retire && (issue_rd == head.rs1)) begin
            op1 = alu_result;
        end
        op2 = rf[head.rs2];
        if (head.use_imm) begin
            op2 = head.imm;
        end else if (head.rs2 == 3'd0) begin
            op2 = '0;
        end else if (retire && (issue_rd == head.rs2)) begin
            op2 = alu_result;
        end
    end

    // Issue register: loads the ALU drive registers on pop, otherwise holds them and issues a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid    <= 1'b0;
            issue_rd       <= '0;
            alu_opcode     <= '0;
            alu_input1     <= '0;
            alu_input2     <= '0;
            alu_shiftValue <= '0;
        end else begin
            issue_valid <= pop;
            if (pop) begin
                issue_rd       <= head.rd;
                alu_opcode     <= head.opcode;
                alu_input1     <= op1;
                alu_input2     <= op2;
                alu_shiftValue <= head.shamt;
            end
        end
    end

    // Writeback strobe, data and sticky flags; idle cycles leave data and flags untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_valid <= 1'b0;
            bus.wb_rd    <= '0;
            bus.wb_data  <= '0;
            bus.flags    <= '0;
        end else begin
            bus.wb_valid <= retire;
            if (retire) begin
                bus.wb_rd   <= issue_rd;
                bus.wb_data <= alu_result;
                bus.flags   <= {alu_carry, alu_zero, alu_overflow, alu_sign};
            end
        end
    end

    // Register file; r0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (retire && (issue_rd != 3'd0)) begin
            rf[issue_rd] <= alu_result;
        end
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural ALU, architectural RF model and writeback scoreboard.
// Latency: expected results are queued at acceptance and compared at each wb_valid.
// Backpressure: hold and full-FIFO behaviour exercised directly by the scenario tasks.
module tb_alu_issue_wb;
    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        logic [3:0] flags;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_input1;
    logic [7:0]  alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_sign;
    logic [2:0]  rf_rd_addr;
    logic [7:0]  rf_rd_data;
    logic [11:0] alu_pack;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [7:0]  tb_rf [8];
    int          errors = 0;
    int          checks = 0;

    alu_issue_wb_if #(.WIDTH(8)) bus ();

    alu_issue_wb #(.WIDTH(8), .DEPTH(4), .NREGS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .hold           (hold),
        .alu_opcode     (alu_opcode),
        .alu_input1     (alu_input1),
        .alu_input2     (alu_input2),
        .alu_shiftValue (alu_shiftValue),
        .alu_result     (alu_result),
        .alu_carry      (alu_carry),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .alu_sign       (alu_sign),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_data     (rf_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {C,Z,V,S,result}.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [4:0] sh);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        logic [2:0] k;
        s = '0; r = '0; c = 1'b0; v = 1'b0; k = sh[2:0];
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = (sh >= 5'd8) ? 8'h00 : (a << sh);
            4'd5: r = (k == 3'd0) ? a : ((a << k) | (a >> (4'd8 - {1'b0, k})));
            4'd6: r = (b == 8'h00) ? 8'h00 : (a / b);
            4'd7: r = b;
            4'd8: r = (a == b) ? 8'h01 : 8'h00;
            default: r = 8'h00;
        endcase
        return {c, (r == 8'h00), v, r[7], r};
    endfunction

    // Environment ALU driven from the DUT's registered outputs.
    always_comb alu_pack = alu_f(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    assign {alu_carry, alu_zero, alu_overflow, alu_sign, alu_result} = alu_pack;

    // Scoreboard: every writeback must match the oldest expected retirement.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected rd=%0d data=%h (no retirement expected)", bus.wb_rd, bus.wb_data);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.wb_rd, bus.wb_data, bus.flags} !== {mon_e.rd, mon_e.data, mon_e.flags}) begin
                    errors++;
                    $display("FAIL wb_result got rd=%0d data=%h flags=%b expected rd=%0d data=%h flags=%b",
                             bus.wb_rd, bus.wb_data, bus.flags, mon_e.rd, mon_e.data, mon_e.flags);
                end
            end
        end
    end

    task automatic model_accept(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic ui, input logic [7:0] imm,
                                input logic [4:0] sh);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] r;
        exp_t        e;
        a = (rs1 == 3'd0) ? 8'h00 : tb_rf[rs1];
        b = ui ? imm : ((rs2 == 3'd0) ? 8'h00 : tb_rf[rs2]);
        r = alu_f(op, a, b, sh);
        if (op <= 4'd8) begin
            e.rd = rd; e.data = r[7:0]; e.flags = r[11:8];
            sb.push_back(e);
            if (rd != 3'd0) tb_rf[rd] = r[7:0];
        end
    endtask

    // Offer one instruction until accepted; called and returns 1 time unit after a rising edge.
    task automatic push(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ui, input logic [7:0] imm, input logic [4:0] sh);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_rs2 = rs2; bus.in_use_imm = ui; bus.in_imm = imm; bus.in_shamt = sh;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (ok) begin
            model_accept(op, rd, rs1, rs2, ui, imm, sh);
        end else begin
            checks++; errors++;
            $display("FAIL push_timeout in_ready stayed low, expected acceptance");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_pending got %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b expected 1", bus.in_ready); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b expected 0", bus.wb_valid); end
        checks++; if (bus.wb_rd !== 3'd0) begin errors++; $display("FAIL rst_wb_rd got %0d expected 0", bus.wb_rd); end
        checks++; if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL rst_wb_data got %h expected 00", bus.wb_data); end
        checks++; if (bus.flags !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b expected 0000", bus.flags); end
        checks++; if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== 25'd0) begin
            errors++; $display("FAIL rst_alu_regs got op=%0d in1=%h in2=%h sh=%0d expected all 0",
                               alu_opcode, alu_input1, alu_input2, alu_shiftValue); end
        for (int a = 0; a < 8; a++) begin
            rf_rd_addr = 3'(a);
            #1;
            checks++; if (rf_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rf r%0d got %h expected 00", a, rf_rd_data); end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_chain();
        push(4'd7, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 5'd0);
        push(4'd0, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00, 5'd0);
        push(4'd1, 3'd3, 3'd2, 3'd1, 1'b0, 8'h00, 5'd0);
        @(negedge clk);
        checks++; if ({alu_opcode, alu_input1, alu_input2} !== {4'd0, 8'h05, 8'h05}) begin
            errors++; $display("FAIL chain_add_fwd got op=%0d in=%h/%h expected 0 05/05", alu_opcode, alu_input1, alu_input2); end
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL chain_wb1 got %b expected 1", bus.wb_valid); end
        @(negedge clk);
        checks++; if ({alu_opcode, alu_input1, alu_input2} !== {4'd1, 8'h0A, 8'h05}) begin
            errors++; $display("FAIL chain_sub_fwd got op=%0d in=%h/%h expected 1 0A/05", alu_opcode, alu_input1, alu_input2); end
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL chain_wb2 got %b expected 1", bus.wb_valid); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL chain_wb3 got %b expected 1", bus.wb_valid); end
        checks++; if ({bus.flags[2], bus.flags[0]} !== 2'b00) begin
            errors++; $display("FAIL chain_flags got Z=%b S=%b expected Z=0 S=0", bus.flags[2], bus.flags[0]); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_backpressure();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'd7, 3'(i), 3'd0, 3'd0, 1'b1, 8'(i), 5'd0);
        bus.in_valid = 1'b1; bus.in_opcode = 4'd7; bus.in_rd = 3'd5; bus.in_rs1 = 3'd0;
        bus.in_rs2 = 3'd0; bus.in_use_imm = 1'b1; bus.in_imm = 8'h05; bus.in_shamt = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b expected 0", bus.in_ready); end
            checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_hold_wb got %b expected 0", bus.wb_valid); end
        end
        @(posedge clk); #1;
        hold = 1'b0;
        push(4'd7, 3'd5, 3'd0, 3'd0, 1'b1, 8'h05, 5'd0);
        drain();
    endtask

    task automatic test_r0_nop();
        push(4'd7, 3'd0, 3'd0, 3'd0, 1'b1, 8'hFF, 5'd0);
        drain();
        rf_rd_addr = 3'd0;
        @(negedge clk);
        checks++; if (rf_rd_data !== 8'h00) begin errors++; $display("FAIL r0_read got %h expected 00", rf_rd_data); end
        checks++; if (bus.flags !== 4'b0001) begin errors++; $display("FAIL r0_flags got %b expected 0001", bus.flags); end
        @(posedge clk); #1;
        push(4'd12, 3'd5, 3'd1, 3'd2, 1'b0, 8'h33, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({bus.wb_valid, bus.flags} !== 5'b0_0001) begin
                errors++; $display("FAIL nop_quiet got wb_valid=%b flags=%b expected 0 0001", bus.wb_valid, bus.flags); end
        end
        rf_rd_addr = 3'd5;
        #1;
        checks++; if (rf_rd_data !== tb_rf[5]) begin errors++; $display("FAIL nop_rf got %h expected %h", rf_rd_data, tb_rf[5]); end
        @(posedge clk); #1;
    endtask

    task automatic test_flags();
        push(4'd7, 3'd1, 3'd0, 3'd0, 1'b1, 8'h80, 5'd0);
        push(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 8'h80, 5'd0);
        drain();
        checks++; if (bus.flags !== 4'b1110) begin errors++; $display("FAIL add_flags got %b expected 1110", bus.flags); end
        checks++; if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL add_data got %h expected 00", bus.wb_data); end
        push(4'd6, 3'd3, 3'd1, 3'd0, 1'b1, 8'h00, 5'd0);
        drain();
        checks++; if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL div0_data got %h expected 00", bus.wb_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            push(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 5'($urandom_range(0, 31)));
        end
        drain();
        for (int a = 0; a < 8; a++) begin
            rf_rd_addr = 3'(a);
            @(negedge clk);
            checks++; if (rf_rd_data !== tb_rf[a]) begin errors++; $display("FAIL b2b_rf r%0d got %h expected %h", a, rf_rd_data, tb_rf[a]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        hold = 1'b1;
        push(4'd7, 3'd1, 3'd0, 3'd0, 1'b1, 8'h11, 5'd0);
        push(4'd7, 3'd2, 3'd0, 3'd0, 1'b1, 8'h22, 5'd0);
        push(4'd7, 3'd3, 3'd0, 3'd0, 1'b1, 8'h33, 5'd0);
        hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        for (int a = 0; a < 8; a++) tb_rf[a] = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
                errors++; $display("FAIL midrst_quiet got wb_valid=%b in_ready=%b expected 0 1", bus.wb_valid, bus.in_ready); end
        end
        for (int a = 1; a <= 3; a++) begin
            rf_rd_addr = 3'(a);
            #1;
            checks++; if (rf_rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rf r%0d got %h expected 00", a, rf_rd_data); end
        end
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 4; i <= 6; i++) push(4'd7, 3'(i), 3'd0, 3'd0, 1'b1, 8'(i), 5'd0);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_count got in_ready=%b after 3 pushes expected 1", bus.in_ready); end
        @(posedge clk); #1;
        hold = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; rf_rd_addr = 3'd0;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0; bus.in_shamt = '0;
        for (int a = 0; a < 8; a++) tb_rf[a] = 8'h00;
        test_reset();
        test_chain();
        test_backpressure();
        test_r0_nop();
        test_flags();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Operand-issue and writeback stage wrapped around the combinational 8-bit ALU (opcodes ADD=0, SUB=1, AND=2, OR=3, SLL=4, ROL=5, DIV=6, PASSB=7, SEQ=8). It buffers incoming register-form instructions in a small FIFO and reads operands from an internal register file, forwarding results where an earlier instruction has not yet been written back. It drives the ALU's opcode, input1, input2 and shiftValue from registers, then captures the ALU result and flags. It writes the result back to the register file and reports each retired op on a writeback strobe.

## Interface
- WIDTH, 8, datapath width (matches ALU)
- DEPTH, 4, instruction FIFO entries (power of two)
- NREGS, 8, register-file entries; r0 is hardwired to zero
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept; equals !full
- in_opcode  in  4  ALU opcode
- in_rd, in_rs1, in_rs2  in  3 each  destination and source register indices
- in_use_imm  in  1  1: input2 = in_imm instead of rs2
- in_imm  in  WIDTH  immediate
- in_shamt  in  5  shift amount, passed to shiftValue
- hold  in  1  stall issue; no pop while high
- alu_opcode  out  4  registered, to ALU opcode
- alu_input1, alu_input2  out  WIDTH each  registered, to ALU
- alu_shiftValue  out  5  registered, to ALU
- alu_result  in  WIDTH  ALU result
- alu_carry, alu_zero, alu_overflow, alu_sign  in  1 each  ALU flags
- wb_valid  out  1  one-cycle pulse per retired op
- wb_rd  out  3  retired destination
- wb_data  out  WIDTH  retired result
- flags  out  4  {C,Z,V,S}, sticky since last retirement
- rf_rd_addr  in  3  debug read address
- rf_rd_data  out  WIDTH  combinational RF read; no forwarding; r0 reads 0

## Operation
- **FIFO**
  - Push on in_valid && in_ready.
  - Pop when count>0 && !hold.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - in_ready is derived only from the registered count. At full, in_ready=0 even if a pop occurs that cycle.
  - Entries leave in order.
- **Issue register**
  - On pop, the head entry loads alu_opcode, alu_shiftValue, issue_rd and issue_valid=1.
  - It also loads alu_input1 = opnd(rs1).
  - It also loads alu_input2 = in_use_imm ? imm : opnd(rs2).
  - With no pop, issue_valid=0. The alu_* registers hold their previous values.
- **opnd(r)**
  - r==0: 0.
  - Else if issue_valid && issue_rd==r && issue_opcode<=8: alu_result (forward from the op currently in the ALU).
  - Else: RF[r].
- **Retire**, on the edge ending a cycle with issue_valid=1:
  - If issue_opcode<=8:
    - Write RF[issue_rd] = alu_result, unless issue_rd==0.
    - Load wb_valid=1, wb_rd, wb_data=alu_result.
    - Load flags={alu_carry, alu_zero, alu_overflow, alu_sign}.
  - If issue_opcode is 9–15: NOP. No RF write, flags unchanged, wb_valid=0.
  - A write to r0 still pulses wb_valid, with wb_rd=0 and wb_data=alu_result.
- **Idle retire cycle**: wb_valid=0; wb_rd, wb_data and flags hold.
- The block never stalls on hazards. Forwarding covers the only in-flight distance, because RF is written at the same edge the dependent op is issued.

## Timing
- Reset (synchronous, rst high at an edge) sets:
  - FIFO empty, count=0, in_ready=1
  - issue_valid=0; alu_opcode, alu_input1, alu_input2, alu_shiftValue = 0
  - wb_valid=0, wb_rd=0, wb_data=0, flags=0
  - all RF entries = 0
- Reset mid-operation discards FIFO contents and the in-flight op; no write occurs at the reset edge.
- Latency, for an instruction accepted at edge k with the FIFO empty and hold=0:
  - popped into the issue register at edge k+1
  - ALU outputs valid during cycle k+1..k+2
  - RF written and wb_* loaded at edge k+2
  - wb_valid high for the cycle after edge k+2
- Throughput is one op per cycle.
- hold asserted: the next edge issues a bubble. The FIFO keeps accepting until count==DEPTH.
- A push into a FIFO with count==0 is not visible to the pop decision in the same cycle (no fall-through).

## Test plan
- **Reset:** rst=1 for 2 cycles.
  - Expect all outputs at the reset values and in_ready=1.
  - Expect rf_rd_data=0 for every address.
- **Immediate load and dependent chain:**
  - Stimulus: PASSB r1←imm 8'h05, then ADD r2=r1+r1, then SUB r3=r2−r1 (imm 0), issued back-to-back.
  - Expect wb_data 05, 0A, 05 on consecutive cycles.
  - Expect ADD alu_input1/input2 = 05/05 via forwarding.
  - Expect final flags Z=0, S=0.
- **Backpressure:**
  - Stimulus: hold=1, push 5 ops (PASSB r1..r5 ← 1..5).
  - Expect in_ready=0 after the 4th push; the 5th is not accepted until space frees.
  - Release hold. Expect wb_rd sequence 1,2,3,4 and then 5 once pushed.
  - Expect no wb_valid while hold=1.
- **r0 and NOP:**
  - PASSB r0←8'hFF: expect wb_valid=1, wb_rd=0, wb_data=FF, and rf_rd_data(0)=0.
  - Opcode 12: expect no wb_valid and flags unchanged.
- **Flags:**
  - ADD 8'h80+8'h80 (r1=80 via PASSB, imm 80): expect wb_data=00 and flags C=1, Z=1, V=1, S=0 as supplied by the ALU.
  - DIV r1/imm 0: expect wb_data=00.
- **Reset mid-flight:**
  - Stimulus: queue 3 ops, assert rst on the cycle the first is in the issue register.
  - Expect no wb_valid afterward, count=0, and RF unchanged from 0.
